// File: rtl/id_issue.sv
// ---------------------------------------------------------------------------
// id_issue : decode / operand-read / issue stage with a register scoreboard.
//
// Takes one instruction per cycle from fetch, decodes its class from
// opcode[6:4], reads rd/rs from an NREG x XLEN register file (bypassing a
// same-cycle write-back) and issues into a single registered output stage.
// A per-register pending bit blocks issue of any instruction whose sources
// still await a write-back from the execute stage.
//
// Ports
//   clk, rst             clock, synchronous active-low reset
//   inst_i, inst_pc_i    fetched instruction and its PC
//   inst_vld_i/_rdy_o    fetch handshake (accepted when both high)
//   ex_stall_i           execute stall: output stage holds
//   ex_branch_en_i       taken branch: output stage loads a bubble
//   ex_wb_en_i, ex_rd_addr_i, ex_result_i   write-back port
//   rd_value_o, rs_value_o, imm_value_o     operands to execute
//   rd_addr_o, pc_value_o, opcode_o         issued instruction fields
//   ctrl_*_o, immf_o, rsv_o                 decoded controls
// ---------------------------------------------------------------------------
module id_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [15:0]     inst_pc_i,
    input  logic            inst_vld_i,
    output logic            inst_rdy_o,
    input  logic            ex_stall_i,
    input  logic            ex_branch_en_i,
    input  logic            ex_wb_en_i,
    input  logic [3:0]      ex_rd_addr_i,
    input  logic [XLEN-1:0] ex_result_i,
    output logic [XLEN-1:0] rd_value_o,
    output logic [XLEN-1:0] rs_value_o,
    output logic [XLEN-1:0] imm_value_o,
    output logic [3:0]      rd_addr_o,
    output logic [15:0]     pc_value_o,
    output logic [6:0]      opcode_o,
    output logic            ctrl_inte_o,
    output logic            ctrl_logic_o,
    output logic            ctrl_shift_o,
    output logic            ctrl_ld_o,
    output logic            ctrl_st_o,
    output logic            ctrl_br_o,
    output logic            immf_o,
    output logic            rsv_o
);

    // Contents of the output stage; an all-zero value is a bubble.
    typedef struct packed {
        logic [XLEN-1:0] rd_value;
        logic [XLEN-1:0] rs_value;
        logic [XLEN-1:0] imm_value;
        logic [3:0]      rd_addr;
        logic [15:0]     pc_value;
        logic [6:0]      opcode;
        logic [5:0]      ctrl;      // {inte, logic, shift, ld, st, br}
        logic            immf;
        logic            rsv;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // One-hot control vector for an instruction class; classes 6/7 are nops.
    function automatic logic [5:0] decode_ctrl(input logic [2:0] cls);
        logic [5:0] ctrl;
        case (cls)
            3'd0:    ctrl = 6'b100000;
            3'd1:    ctrl = 6'b010000;
            3'd2:    ctrl = 6'b001000;
            3'd3:    ctrl = 6'b000100;
            3'd4:    ctrl = 6'b000010;
            3'd5:    ctrl = 6'b000001;
            default: ctrl = 6'b000000;
        endcase
        return ctrl;
    endfunction

    // Instruction fields
    logic [6:0]  opcode_s;
    logic [2:0]  cls_s;
    logic [3:0]  rd_s;
    logic [3:0]  rs_s;
    logic        immf_s;
    logic [15:0] imm_s;

    assign opcode_s = inst_i[31:25];
    assign cls_s    = inst_i[31:29];
    assign rd_s     = inst_i[24:21];
    assign rs_s     = inst_i[20:17];
    assign immf_s   = inst_i[16];
    assign imm_s    = inst_i[15:0];

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    stage_t          stage_q;
    stage_t          stage_d;

    logic            wb_hit_rd_s;
    logic            wb_hit_rs_s;
    logic            uses_rd_s;
    logic            uses_rs_s;
    logic            hazard_s;
    logic            accept_s;
    logic            dec_rsv_s;
    logic [XLEN-1:0] rd_read_s;
    logic [XLEN-1:0] rs_read_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    stage_t          dec_stage_s;

    assign wb_hit_rd_s = ex_wb_en_i && (ex_rd_addr_i == rd_s);
    assign wb_hit_rs_s = ex_wb_en_i && (ex_rd_addr_i == rs_s);

    // Nops (class 6/7) read nothing; rs is a source only without an immediate.
    assign uses_rd_s = (cls_s < 3'd6);
    assign uses_rs_s = uses_rd_s && !immf_s;
    assign dec_rsv_s = (cls_s < 3'd4);

    // A same-cycle write-back to a pending source resolves the hazard.
    assign hazard_s = (uses_rd_s && pending_q[rd_s] && !wb_hit_rd_s) ||
                      (uses_rs_s && pending_q[rs_s] && !wb_hit_rs_s);

    // Reset gates the handshake so nothing is consumed during the reset cycle.
    assign inst_rdy_o = rst && !ex_stall_i && !hazard_s && !ex_branch_en_i;
    assign accept_s   = inst_vld_i && inst_rdy_o;

    // Operand read with write-back bypass
    always_comb begin
        if (wb_hit_rd_s) begin
            rd_read_s = ex_result_i;
        end else begin
            rd_read_s = rf_q[rd_s];
        end
        if (wb_hit_rs_s) begin
            rs_read_s = ex_result_i;
        end else begin
            rs_read_s = rf_q[rs_s];
        end
    end

    // Assemble the decoded instruction as it would enter the output stage
    always_comb begin
        dec_stage_s           = BUBBLE;
        dec_stage_s.rd_value  = rd_read_s;
        dec_stage_s.rs_value  = rs_read_s;
        dec_stage_s.imm_value = {{(XLEN-16){imm_s[15]}}, imm_s};
        dec_stage_s.rd_addr   = rd_s;
        dec_stage_s.pc_value  = inst_pc_i;
        dec_stage_s.opcode    = opcode_s;
        dec_stage_s.ctrl      = decode_ctrl(cls_s);
        dec_stage_s.immf      = immf_s;
        dec_stage_s.rsv       = dec_rsv_s;
    end

    // Output stage next state: branch flush beats stall, stall beats issue
    always_comb begin
        stage_d = BUBBLE;
        if (ex_branch_en_i) begin
            stage_d = BUBBLE;
        end else if (ex_stall_i) begin
            stage_d = stage_q;
        end else if (accept_s) begin
            stage_d = dec_stage_s;
        end else begin
            stage_d = BUBBLE;
        end
    end

    // Scoreboard next state: set is applied after clear so it wins on a tie
    always_comb begin
        clr_mask_s = {NREG{1'b0}};
        set_mask_s = {NREG{1'b0}};
        if (ex_wb_en_i) begin
            clr_mask_s = {{(NREG-1){1'b0}}, 1'b1} << ex_rd_addr_i;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        if (accept_s && dec_rsv_s) begin
            set_mask_s = {{(NREG-1){1'b0}}, 1'b1} << rd_s;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
    end

    // Output stage and scoreboard registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q   <= BUBBLE;
            pending_q <= {NREG{1'b0}};
        end else begin
            stage_q   <= stage_d;
            pending_q <= pending_d;
        end
    end

    // Register file write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= {XLEN{1'b0}};
            end
        end else if (ex_wb_en_i) begin
            rf_q[ex_rd_addr_i] <= ex_result_i;
        end
    end

    assign rd_value_o   = stage_q.rd_value;
    assign rs_value_o   = stage_q.rs_value;
    assign imm_value_o  = stage_q.imm_value;
    assign rd_addr_o    = stage_q.rd_addr;
    assign pc_value_o   = stage_q.pc_value;
    assign opcode_o     = stage_q.opcode;
    assign ctrl_inte_o  = stage_q.ctrl[5];
    assign ctrl_logic_o = stage_q.ctrl[4];
    assign ctrl_shift_o = stage_q.ctrl[3];
    assign ctrl_ld_o    = stage_q.ctrl[2];
    assign ctrl_st_o    = stage_q.ctrl[1];
    assign ctrl_br_o    = stage_q.ctrl[0];
    assign immf_o       = stage_q.immf;
    assign rsv_o        = stage_q.rsv;

endmodule

// File: tb/tb_id_issue.sv
// ---------------------------------------------------------------------------
// tb_id_issue : self-checking bench for id_issue. Directed scenarios plus a
// randomized run compared against a behavioural model (register array,
// pending-bit array and the expected content of the output stage).
// ---------------------------------------------------------------------------
module tb_id_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] inst;
    logic [15:0] pc;
    logic        vld, stall, br, wb;
    logic [3:0]  wb_addr;
    logic [31:0] wb_res;

    logic        inst_rdy_o;
    logic [31:0] rd_value_o, rs_value_o, imm_value_o;
    logic [3:0]  rd_addr_o;
    logic [15:0] pc_value_o;
    logic [6:0]  opcode_o;
    logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
    logic        immf_o, rsv_o;

    id_issue #(.XLEN(32), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .inst_i(inst), .inst_pc_i(pc), .inst_vld_i(vld), .inst_rdy_o(inst_rdy_o),
        .ex_stall_i(stall), .ex_branch_en_i(br),
        .ex_wb_en_i(wb), .ex_rd_addr_i(wb_addr), .ex_result_i(wb_res),
        .rd_value_o(rd_value_o), .rs_value_o(rs_value_o), .imm_value_o(imm_value_o),
        .rd_addr_o(rd_addr_o), .pc_value_o(pc_value_o), .opcode_o(opcode_o),
        .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o),
        .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o),
        .immf_o(immf_o), .rsv_o(rsv_o)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [16];
    logic [15:0] m_pend;
    logic [5:0]  e_ctrl;
    logic        e_immf, e_rsv;
    logic [6:0]  e_op;
    logic [3:0]  e_rd;
    logic [15:0] e_pc;
    logic [31:0] e_rdv, e_rsval, e_imm;

    logic [5:0]  ctrl_all;
    assign ctrl_all = {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o};

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic immf, input logic [15:0] imm);
        return {op, rd, rs, immf, imm};
    endfunction

    function automatic logic busy(input logic [3:0] r);
        return m_pend[r] && !(wb && wb_addr == r);
    endfunction

    function automatic logic model_rdy();
        logic is_nop;
        logic haz;
        is_nop = (inst[31:29] >= 3'd6);
        haz = !is_nop && (busy(inst[24:21]) || (!inst[16] && busy(inst[20:17])));
        return rst && !stall && !br && !haz;
    endfunction

    function automatic logic [31:0] rdval(input logic [3:0] r);
        return (wb && wb_addr == r) ? wb_res : m_rf[r];
    endfunction

    task automatic set_bubble();
        e_ctrl = 6'd0; e_immf = 1'b0; e_rsv = 1'b0; e_op = 7'd0; e_rd = 4'd0;
        e_pc = 16'd0; e_rdv = 32'd0; e_rsval = 32'd0; e_imm = 32'd0;
    endtask

    task automatic model_tick();
        logic       take;
        logic [2:0] cls;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
            m_pend = 16'd0;
            set_bubble();
        end else begin
            take = vld && model_rdy();
            cls  = inst[31:29];
            if (br) begin
                set_bubble();
            end else if (stall) begin
                // output stage keeps what it had
            end else if (take) begin
                case (cls)
                    3'd0: e_ctrl = 6'b100000;
                    3'd1: e_ctrl = 6'b010000;
                    3'd2: e_ctrl = 6'b001000;
                    3'd3: e_ctrl = 6'b000100;
                    3'd4: e_ctrl = 6'b000010;
                    3'd5: e_ctrl = 6'b000001;
                    default: e_ctrl = 6'b000000;
                endcase
                e_rsv   = (cls <= 3'd3);
                e_immf  = inst[16];
                e_op    = inst[31:25];
                e_rd    = inst[24:21];
                e_pc    = pc;
                e_rdv   = rdval(inst[24:21]);
                e_rsval = rdval(inst[20:17]);
                e_imm   = {{16{inst[15]}}, inst[15:0]};
            end else begin
                set_bubble();
            end
            if (wb) m_pend[wb_addr] = 1'b0;
            if (take && cls <= 3'd3) m_pend[inst[24:21]] = 1'b1;
            if (wb) m_rf[wb_addr] = wb_res;
        end
    endtask

    // Advance one clock; inputs are those currently driven.
    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; vld = 1'b0; stall = 1'b0; br = 1'b0; wb = 1'b0;
        wb_addr = 4'd0; wb_res = 32'd0; inst = 32'd0; pc = 16'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 1'b0; vld = 1'b1; inst = mk(7'h00, 4'd1, 4'd2, 1'b0, 16'h0); wb = 1'b1; wb_addr = 4'd3; wb_res = 32'hDEAD;
        #1;
        total++; if (inst_rdy_o !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%0b want=0", inst_rdy_o); end
        tick(); tick();
        total++; if ({ctrl_all, immf_o, rsv_o} !== 8'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", {ctrl_all, immf_o, rsv_o}); end
        total++; if ({rd_value_o, rs_value_o, imm_value_o, rd_addr_o, pc_value_o, opcode_o} !== 123'd0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {rd_value_o, rs_value_o, imm_value_o, rd_addr_o, pc_value_o, opcode_o}); end
        idle();
        tick();
        total++; if (ctrl_all !== 6'd0) begin bad++; $display("FAIL reset_no_issue got=%b want=0", ctrl_all); end
    endtask

    task automatic test_add();
        idle();
        vld = 1'b1; inst = mk(7'h00, 4'd1, 4'd2, 1'b0, 16'h0); pc = 16'h0010;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL add_rdy got=%0b want=1", inst_rdy_o); end
        tick();
        vld = 1'b0;
        total++; if ({ctrl_all, rsv_o} !== 7'b1000001) begin bad++; $display("FAIL add_ctrl got=%b want=1000001", {ctrl_all, rsv_o}); end
        total++; if (rd_addr_o !== 4'd1 || pc_value_o !== 16'h0010) begin bad++; $display("FAIL add_fields rd=%0d pc=%h want 1/0010", rd_addr_o, pc_value_o); end
        total++; if (rd_value_o !== 32'd0 || rs_value_o !== 32'd0) begin bad++; $display("FAIL add_values rd=%h rs=%h want 0/0", rd_value_o, rs_value_o); end
    endtask

    task automatic test_hazard();
        idle();
        vld = 1'b1; inst = mk(7'h00, 4'd1, 4'd3, 1'b0, 16'h0); pc = 16'h0014;
        #1;
        total++; if (inst_rdy_o !== 1'b0) begin bad++; $display("FAIL haz_rdy got=%0b want=0", inst_rdy_o); end
        tick();
        total++; if (ctrl_all !== 6'd0 || opcode_o !== 7'd0) begin bad++; $display("FAIL haz_bubble ctrl=%b op=%h want 0", ctrl_all, opcode_o); end
        wb = 1'b1; wb_addr = 4'd1; wb_res = 32'h1234;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL haz_wb_rdy got=%0b want=1", inst_rdy_o); end
        tick();
        total++; if (rd_value_o !== 32'h1234 || ctrl_inte_o !== 1'b1) begin bad++; $display("FAIL haz_bypass rd=%h inte=%0b want 1234/1", rd_value_o, ctrl_inte_o); end
        wb = 1'b0;
        #1;
        total++; if (inst_rdy_o !== 1'b0) begin bad++; $display("FAIL haz_set_wins got=%0b want=0", inst_rdy_o); end
        vld = 1'b0; wb = 1'b1; wb_addr = 4'd1; wb_res = 32'h1234;
        tick();
        wb = 1'b0;
    endtask

    task automatic test_imm();
        idle();
        vld = 1'b1; inst = mk(7'h30, 4'd1, 4'd0, 1'b1, 16'h0);
        tick();
        inst = mk(7'h40, 4'd2, 4'd1, 1'b1, 16'h8000); pc = 16'h0020;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL imm_rs_ignored got=%0b want=1", inst_rdy_o); end
        tick();
        total++; if (imm_value_o !== 32'hFFFF8000) begin bad++; $display("FAIL imm_neg got=%h want=ffff8000", imm_value_o); end
        total++; if ({ctrl_all, immf_o, rsv_o} !== 8'b00001010) begin bad++; $display("FAIL imm_st_ctrl got=%b want=00001010", {ctrl_all, immf_o, rsv_o}); end
        inst = mk(7'h40, 4'd2, 4'd1, 1'b1, 16'h7FFF);
        tick();
        total++; if (imm_value_o !== 32'h00007FFF) begin bad++; $display("FAIL imm_pos got=%h want=00007fff", imm_value_o); end
        inst = mk(7'h40, 4'd2, 4'd1, 1'b0, 16'h7FFF);
        #1;
        total++; if (inst_rdy_o !== 1'b0) begin bad++; $display("FAIL imm_rs_checked got=%0b want=0", inst_rdy_o); end
        vld = 1'b0; wb = 1'b1; wb_addr = 4'd1; wb_res = 32'h55;
        tick();
        wb = 1'b0;
    endtask

    task automatic test_stall();
        idle();
        vld = 1'b1; inst = mk(7'h10, 4'd4, 4'd5, 1'b0, 16'h0); pc = 16'h0044;
        tick();
        stall = 1'b1; inst = mk(7'h10, 4'd6, 4'd7, 1'b0, 16'h0); pc = 16'h0048;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (inst_rdy_o !== 1'b0) begin bad++; $display("FAIL stall_rdy cyc=%0d got=%0b want=0", i, inst_rdy_o); end
            tick();
            total++; if (ctrl_logic_o !== 1'b1 || rd_addr_o !== 4'd4 || pc_value_o !== 16'h0044) begin
                bad++; $display("FAIL stall_hold cyc=%0d logic=%0b rd=%0d pc=%h want 1/4/0044", i, ctrl_logic_o, rd_addr_o, pc_value_o); end
        end
        stall = 1'b0;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL stall_release_rdy got=%0b want=1", inst_rdy_o); end
        tick();
        vld = 1'b0;
        total++; if (rd_addr_o !== 4'd6 || pc_value_o !== 16'h0048) begin bad++; $display("FAIL stall_next rd=%0d pc=%h want 6/0048", rd_addr_o, pc_value_o); end
    endtask

    task automatic test_branch();
        idle();
        vld = 1'b1; inst = mk(7'h00, 4'd8, 4'd9, 1'b0, 16'h0); pc = 16'h0050;
        tick();
        br = 1'b1; stall = 1'b1; inst = mk(7'h00, 4'd10, 4'd11, 1'b0, 16'h0); pc = 16'h0060;
        #1;
        total++; if (inst_rdy_o !== 1'b0) begin bad++; $display("FAIL br_rdy got=%0b want=0", inst_rdy_o); end
        tick();
        total++; if ({ctrl_all, immf_o, rsv_o, rd_addr_o} !== 12'd0) begin bad++; $display("FAIL br_bubble got=%h want=0", {ctrl_all, immf_o, rsv_o, rd_addr_o}); end
        br = 1'b0; stall = 1'b0;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL br_not_consumed got=%0b want=1", inst_rdy_o); end
        tick();
        vld = 1'b0;
        total++; if (rd_addr_o !== 4'd10 || pc_value_o !== 16'h0060) begin bad++; $display("FAIL br_reissue rd=%0d pc=%h want 10/0060", rd_addr_o, pc_value_o); end
    endtask

    task automatic test_nop();
        idle();
        vld = 1'b1; inst = mk(7'h70, 4'd8, 4'd8, 1'b0, 16'h0); pc = 16'h0070;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL nop_no_read got=%0b want=1", inst_rdy_o); end
        tick();
        total++; if ({ctrl_all, rsv_o} !== 7'd0 || opcode_o !== 7'h70 || rd_addr_o !== 4'd8) begin
            bad++; $display("FAIL nop_out ctrl=%b rsv=%0b op=%h rd=%0d want 0/0/70/8", ctrl_all, rsv_o, opcode_o, rd_addr_o); end
        inst = mk(7'h70, 4'd12, 4'd12, 1'b0, 16'h0);
        tick();
        inst = mk(7'h00, 4'd12, 4'd13, 1'b0, 16'h0);
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL nop_no_pending got=%0b want=1", inst_rdy_o); end
        tick();
        vld = 1'b0;
    endtask

    task automatic test_reset_mid();
        idle();
        vld = 1'b1; inst = mk(7'h30, 4'd5, 4'd0, 1'b1, 16'h0);
        tick();
        stall = 1'b1; inst = mk(7'h00, 4'd5, 4'd5, 1'b0, 16'h0);
        rst = 1'b0;
        tick();
        total++; if ({ctrl_all, rsv_o, rd_addr_o} !== 11'd0) begin bad++; $display("FAIL rstmid_out got=%h want=0", {ctrl_all, rsv_o, rd_addr_o}); end
        rst = 1'b1; stall = 1'b0;
        #1;
        total++; if (inst_rdy_o !== 1'b1) begin bad++; $display("FAIL rstmid_pending got=%0b want=1", inst_rdy_o); end
        tick();
        vld = 1'b0;
    endtask

    task automatic test_random();
        idle();
        rst = 1'b0;
        tick();
        for (int n = 0; n < 800; n++) begin
            rst     = ($urandom_range(0, 49) != 0);
            vld     = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            br      = ($urandom_range(0, 9) == 0);
            wb      = ($urandom_range(0, 2) == 0);
            wb_addr = {2'b00, 2'($urandom_range(0, 3))};
            wb_res  = $urandom;
            inst    = mk(7'($urandom), {2'b00, 2'($urandom_range(0, 3))}, {2'b00, 2'($urandom_range(0, 3))},
                         1'($urandom), 16'($urandom));
            pc      = 16'($urandom);
            #1;
            if (vld || !rst) begin
                total++; if (inst_rdy_o !== model_rdy()) begin bad++; $display("FAIL rnd_rdy n=%0d got=%0b want=%0b", n, inst_rdy_o, model_rdy()); end
            end
            tick();
            total++; if ({ctrl_all, immf_o, rsv_o} !== {e_ctrl, e_immf, e_rsv}) begin
                bad++; $display("FAIL rnd_ctrl n=%0d got=%b want=%b", n, {ctrl_all, immf_o, rsv_o}, {e_ctrl, e_immf, e_rsv}); end
            total++; if ({opcode_o, rd_addr_o, pc_value_o} !== {e_op, e_rd, e_pc}) begin
                bad++; $display("FAIL rnd_fields n=%0d got=%h want=%h", n, {opcode_o, rd_addr_o, pc_value_o}, {e_op, e_rd, e_pc}); end
            total++; if ({rd_value_o, rs_value_o, imm_value_o} !== {e_rdv, e_rsval, e_imm}) begin
                bad++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, {rd_value_o, rs_value_o, imm_value_o}, {e_rdv, e_rsval, e_imm}); end
        end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
        m_pend = 16'd0;
        set_bubble();
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_hazard();
        test_imm();
        test_stall();
        test_branch();
        test_nop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_issue.md
ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 Parameter XLEN, 32, operand/result width.
REQ-002 Parameter NREG, 16, register count (4-bit addresses).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-low (rst=0 resets on clk edge).
REQ-005 inst_i  input  32  fetched instruction: [31:25] opcode, [24:21] rd, [20:17] rs, [16] immf, [15:0] imm.
REQ-006 inst_pc_i  input  16  PC of inst_i.
REQ-007 inst_vld_i  input  1  inst_i valid.
REQ-008 inst_rdy_o  output  1  instruction accepted this cycle when inst_vld_i & inst_rdy_o.
REQ-009 ex_stall_i  input  1  execute stage stall request.
REQ-010 ex_branch_en_i  input  1  taken branch from execute stage; flush.
REQ-011 ex_wb_en_i  input  1  write-back enable from execute stage.
REQ-012 ex_rd_addr_i  input  4  write-back address.
REQ-013 ex_result_i  input  XLEN  write-back data.
REQ-014 rd_value_o, rs_value_o, imm_value_o  output  XLEN each  operands to execute stage.
REQ-015 rd_addr_o  output  4; pc_value_o  output  16; opcode_o  output  7.
REQ-016 ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, immf_o, rsv_o  output  1 each  decoded controls.

Function
REQ-017 Decode by opcode[6:4]: 000 inte, 001 logic, 010 shift, 011 ld, 100 st, 101 br, 110/111 no control asserted (nop).
REQ-018 rsv = 1 for inte/logic/shift/ld, 0 for st/br/nop.
REQ-019 imm_value = imm sign-extended to XLEN.
REQ-020 Register file: NREG x XLEN flops; written when ex_wb_en_i, address ex_rd_addr_i, data ex_result_i.
REQ-021 Operand read SHALL bypass: if ex_wb_en_i and ex_rd_addr_i equals read address, value = ex_result_i.
REQ-022 All execute-side outputs SHALL be registered (one output stage); issue latency 1 cycle from acceptance.
REQ-023 Scoreboard: one pending bit per register; set on issue of rsv=1 instruction for its rd; cleared on ex_wb_en_i with matching address; same-cycle set and clear on same register leaves it set.
REQ-024 Sources: rd always; rs only when immf=0; nop reads none.
REQ-025 Hazard = any source pending and not cleared by same-cycle write-back.
REQ-026 inst_rdy_o = !ex_stall_i & !hazard & !ex_branch_en_i.
REQ-027 On acceptance: output stage loads decoded instruction.
REQ-028 On ex_stall_i=1: output stage holds its contents unchanged.
REQ-029 On hazard without stall, or inst_vld_i=0 without stall: output stage loads bubble (all ctrl_*, immf_o, rsv_o = 0; data outputs 0).
REQ-030 On ex_branch_en_i=1: output stage loads bubble regardless of ex_stall_i; inst_i not accepted that cycle; scoreboard unaffected except normal write-back clear.
REQ-031 Output opcode_o, rd_addr_o, pc_value_o track the issued instruction; 0 for bubbles.

Reset
REQ-032 While rst=0 at clk edge: output stage = bubble, all outputs 0, register file all 0, scoreboard all clear.
REQ-033 inst_rdy_o SHALL be 0 during the reset cycle; an instruction presented during reset SHALL NOT issue.
REQ-034 Reset mid-stall or mid-hazard discards held instruction and pending bits.

Verification
REQ-035 Reset, then inst add r1,r2 (opcode 0x00, rd=1, rs=2, immf=0) valid -> next cycle ctrl_inte_o=1, rsv_o=1, rd_addr_o=1, rd_value_o=rs_value_o=0, pending[1]=1.
REQ-036 Issue add r1; next inst reads r1 with no write-back -> inst_rdy_o=0, bubble issued; ex_wb_en_i=1, addr=1, result=0x1234 -> same cycle inst_rdy_o=1, next cycle rd_value_o=0x1234.
REQ-037 imm=0x8000, immf=1 -> imm_value_o=0xFFFF8000; imm=0x7FFF -> 0x00007FFF; rs not hazard-checked.
REQ-038 ex_stall_i=1 for 3 cycles with issued inst -> outputs unchanged 3 cycles, inst_rdy_o=0; release -> next inst issues.
REQ-039 ex_branch_en_i=1 with ex_stall_i=1 and valid inst -> next cycle all ctrl outputs 0, inst not consumed (inst_rdy_o=0).
REQ-040 opcode 0x70 (class 111) -> all ctrl 0, rsv_o=0, no pending bit set.
